// File: rtl/mmu_satp_ctrl.sv
// Multi-context satp register file with WARL MODE legalisation and a
// request/acknowledge TLB flush sequencer for SFENCE.VMA and MODE changes.
module mmu_satp_ctrl #(
    parameter  int XLEN    = 32,
    parameter  int NUM_CTX = 2,
    localparam int CTX_W   = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1,
    localparam int MODE_W  = (XLEN == 64) ? 4  : 1,
    localparam int ASID_W  = (XLEN == 64) ? 16 : 9,
    localparam int PPN_W   = (XLEN == 64) ? 44 : 22
) (
    input  logic                       clk,
    input  logic                       rst_n,

    input  logic                       csr_read_en_i,
    input  logic [11:0]                csr_raddr_i,
    input  logic [CTX_W-1:0]           csr_rctx_i,
    output logic [XLEN-1:0]            csr_rdata_o,

    input  logic                       csr_write_en_i,
    input  logic [11:0]                csr_waddr_i,
    input  logic [CTX_W-1:0]           csr_wctx_i,
    input  logic [XLEN-1:0]            csr_wdata_i,
    output logic                       csr_write_ready_o,

    input  logic                       sfence_valid_i,
    input  logic [CTX_W-1:0]           sfence_ctx_i,
    input  logic                       sfence_asid_valid_i,
    input  logic [ASID_W-1:0]          sfence_asid_i,
    output logic                       sfence_ready_o,
    output logic                       sfence_done_o,

    output logic                       flush_req_o,
    output logic [CTX_W-1:0]           flush_ctx_o,
    output logic                       flush_all_o,
    output logic [ASID_W-1:0]          flush_asid_o,
    input  logic                       flush_ack_i,

    output logic [NUM_CTX*MODE_W-1:0]  satp_mode_o,
    output logic [NUM_CTX*ASID_W-1:0]  satp_asid_o,
    output logic [NUM_CTX*PPN_W-1:0]   satp_ppn_o
);

    localparam logic [11:0] SATP_ADDR = 12'h180;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   satp_q [NUM_CTX];
    logic [XLEN-1:0]   satp_d [NUM_CTX];
    logic              flush_req_q, flush_req_d;
    logic [CTX_W-1:0]  flush_ctx_q, flush_ctx_d;
    logic              flush_all_q, flush_all_d;
    logic [ASID_W-1:0] flush_asid_q, flush_asid_d;
    logic              from_sfence_q, from_sfence_d;
    logic              sfence_done_q, sfence_done_d;

    logic [MODE_W-1:0] wmode;
    logic [MODE_W-1:0] old_mode;
    logic              write_accept;
    logic              mode_change;

    function automatic logic ctx_ok(input logic [CTX_W-1:0] c);
        return 32'(c) < 32'(NUM_CTX);
    endfunction

    // Sv39 only defines Bare (0) and Sv39 (8); every other encoding is dropped.
    function automatic logic mode_legal(input logic [MODE_W-1:0] m);
        if (XLEN == 64) begin
            return (m == MODE_W'(0)) || (m == MODE_W'(8));
        end
        return 1'b1;
    endfunction

    assign csr_write_ready_o = (state_q == IDLE);
    assign sfence_ready_o    = (state_q == IDLE) && !csr_write_en_i;

    assign wmode        = csr_wdata_i[XLEN-1 -: MODE_W];
    assign write_accept = csr_write_en_i && csr_write_ready_o && (csr_waddr_i == SATP_ADDR)
                          && ctx_ok(csr_wctx_i) && mode_legal(wmode);
    assign mode_change  = write_accept && (wmode != old_mode);

    always_comb begin
        old_mode    = '0;
        csr_rdata_o = '0;
        satp_mode_o = '0;
        satp_asid_o = '0;
        satp_ppn_o  = '0;
        for (int i = 0; i < NUM_CTX; i++) begin
            if (csr_wctx_i == CTX_W'(i)) old_mode = satp_q[i][XLEN-1 -: MODE_W];
            if (csr_read_en_i && csr_raddr_i == SATP_ADDR && csr_rctx_i == CTX_W'(i))
                csr_rdata_o = satp_q[i];
            satp_mode_o[i*MODE_W +: MODE_W] = satp_q[i][XLEN-1 -: MODE_W];
            satp_asid_o[i*ASID_W +: ASID_W] = satp_q[i][PPN_W +: ASID_W];
            satp_ppn_o[i*PPN_W +: PPN_W]    = satp_q[i][PPN_W-1:0];
        end
    end

    // NOTE: every signal driven here takes a default first so no latch is inferred.
    always_comb begin
        state_d       = state_q;
        satp_d        = satp_q;
        flush_req_d   = flush_req_q;
        flush_ctx_d   = flush_ctx_q;
        flush_all_d   = flush_all_q;
        flush_asid_d  = flush_asid_q;
        from_sfence_d = from_sfence_q;
        sfence_done_d = 1'b0;

        for (int i = 0; i < NUM_CTX; i++) begin
            if (write_accept && csr_wctx_i == CTX_W'(i)) satp_d[i] = csr_wdata_i;
        end

        case (state_q)
            IDLE: begin
                if (mode_change) begin
                    state_d       = FLUSH;
                    flush_req_d   = 1'b1;
                    flush_ctx_d   = csr_wctx_i;
                    flush_all_d   = 1'b1;
                    flush_asid_d  = '0;
                    from_sfence_d = 1'b0;
                end else if (sfence_valid_i && sfence_ready_o) begin
                    // A context with no satp has nothing cached; acknowledge at once.
                    if (ctx_ok(sfence_ctx_i)) begin
                        state_d       = FLUSH;
                        flush_req_d   = 1'b1;
                        flush_ctx_d   = sfence_ctx_i;
                        flush_all_d   = !sfence_asid_valid_i;
                        flush_asid_d  = sfence_asid_valid_i ? sfence_asid_i : '0;
                        from_sfence_d = 1'b1;
                    end else begin
                        sfence_done_d = 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (flush_ack_i) begin
                    state_d       = IDLE;
                    flush_req_d   = 1'b0;
                    flush_ctx_d   = '0;
                    flush_all_d   = 1'b0;
                    flush_asid_d  = '0;
                    from_sfence_d = 1'b0;
                    sfence_done_d = from_sfence_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            flush_req_q   <= 1'b0;
            flush_ctx_q   <= '0;
            flush_all_q   <= 1'b0;
            flush_asid_q  <= '0;
            from_sfence_q <= 1'b0;
            sfence_done_q <= 1'b0;
            // NOTE: the satp array is architecturally reset to Bare, so it is a reset flop bank, not a RAM.
            for (int i = 0; i < NUM_CTX; i++) satp_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            flush_req_q   <= flush_req_d;
            flush_ctx_q   <= flush_ctx_d;
            flush_all_q   <= flush_all_d;
            flush_asid_q  <= flush_asid_d;
            from_sfence_q <= from_sfence_d;
            sfence_done_q <= sfence_done_d;
            satp_q        <= satp_d;
        end
    end

    assign flush_req_o   = flush_req_q;
    assign flush_ctx_o   = flush_ctx_q;
    assign flush_all_o   = flush_all_q;
    assign flush_asid_o  = flush_asid_q;
    assign sfence_done_o = sfence_done_q;

endmodule

// File: tb/tb_mmu_satp_ctrl.sv
// Bench for mmu_satp_ctrl: Sv32 instance (3 contexts, so ctx 3 is out of range)
// checked against a transaction-level model, plus a small Sv39 WARL check.
module tb_mmu_satp_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Sv32 instance, NUM_CTX = 3 -> CTX_W = 2
    logic        rd_en, wr_en, sf_valid, sf_asid_valid, ack;
    logic [11:0] raddr, waddr;
    logic [1:0]  rctx, wctx, sf_ctx;
    logic [31:0] rdata, wdata;
    logic [8:0]  sf_asid;
    logic        wr_ready, sf_ready, sf_done, f_req, f_all;
    logic [1:0]  f_ctx;
    logic [8:0]  f_asid;
    logic [2:0]  s_mode;
    logic [26:0] s_asid;
    logic [65:0] s_ppn;

    // Sv39 instance, NUM_CTX = 2 -> CTX_W = 1
    logic        rd_en64, wr_en64, ack64;
    logic [11:0] raddr64, waddr64;
    logic        rctx64, wctx64;
    logic [63:0] rdata64, wdata64;
    logic        wr_ready64, sf_ready64, sf_done64, f_req64, f_all64, f_ctx64;
    logic [15:0] f_asid64;
    logic [7:0]  s_mode64;
    logic [31:0] s_asid64;
    logic [87:0] s_ppn64;

    mmu_satp_ctrl #(.XLEN(32), .NUM_CTX(3)) u_dut32 (
        .clk(clk), .rst_n(rst_n),
        .csr_read_en_i(rd_en), .csr_raddr_i(raddr), .csr_rctx_i(rctx), .csr_rdata_o(rdata),
        .csr_write_en_i(wr_en), .csr_waddr_i(waddr), .csr_wctx_i(wctx), .csr_wdata_i(wdata),
        .csr_write_ready_o(wr_ready),
        .sfence_valid_i(sf_valid), .sfence_ctx_i(sf_ctx), .sfence_asid_valid_i(sf_asid_valid),
        .sfence_asid_i(sf_asid), .sfence_ready_o(sf_ready), .sfence_done_o(sf_done),
        .flush_req_o(f_req), .flush_ctx_o(f_ctx), .flush_all_o(f_all), .flush_asid_o(f_asid),
        .flush_ack_i(ack),
        .satp_mode_o(s_mode), .satp_asid_o(s_asid), .satp_ppn_o(s_ppn)
    );

    mmu_satp_ctrl #(.XLEN(64), .NUM_CTX(2)) u_dut64 (
        .clk(clk), .rst_n(rst_n),
        .csr_read_en_i(rd_en64), .csr_raddr_i(raddr64), .csr_rctx_i(rctx64), .csr_rdata_o(rdata64),
        .csr_write_en_i(wr_en64), .csr_waddr_i(waddr64), .csr_wctx_i(wctx64), .csr_wdata_i(wdata64),
        .csr_write_ready_o(wr_ready64),
        .sfence_valid_i(1'b0), .sfence_ctx_i(1'b0), .sfence_asid_valid_i(1'b0),
        .sfence_asid_i(16'h0), .sfence_ready_o(sf_ready64), .sfence_done_o(sf_done64),
        .flush_req_o(f_req64), .flush_ctx_o(f_ctx64), .flush_all_o(f_all64), .flush_asid_o(f_asid64),
        .flush_ack_i(ack64),
        .satp_mode_o(s_mode64), .satp_asid_o(s_asid64), .satp_ppn_o(s_ppn64)
    );

    int n_checks = 0;
    int n_bad    = 0;

    // Reference model: one 32-bit satp word per architectural context.
    logic [31:0] model [3];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change at negedge; one call moves past exactly one rising edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        for (int c = 0; c < 3; c++) begin
            rd_en = 1'b1; raddr = 12'h180; rctx = 2'(c);
            #1;
            check({tag, "_rd"}, rdata, model[c]);
            check({tag, "_mode"}, s_mode[c], model[c][31]);
            check({tag, "_asid"}, s_asid[c*9 +: 9], model[c][30:22]);
            check({tag, "_ppn"}, s_ppn[c*22 +: 22], model[c][21:0]);
        end
        rd_en = 1'b0;
    endtask

    // One write cycle; returns whether the spec says it flushes, and updates the model.
    task automatic do_write(input logic [11:0] a, input logic [1:0] c, input logic [31:0] d,
                            output logic exp_flush);
        logic accept;
        wr_en = 1'b1; waddr = a; wctx = c; wdata = d;
        accept    = (a == 12'h180) && (c < 3);
        exp_flush = accept && (d[31] != model[c][31]);
        if (accept) model[c] = d;
        tick();
        wr_en = 1'b0;
    endtask

    // With a flush pending: hold ack low for `wait_n` cycles, then ack.
    task automatic finish_flush(input string tag, input int wait_n, input logic exp_done);
        for (int k = 0; k < wait_n; k++) begin
            tick();
            check({tag, "_hold_req"}, f_req, 1'b1);
            check({tag, "_hold_wr_rdy"}, wr_ready, 1'b0);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check({tag, "_req_drop"}, f_req, 1'b0);
        check({tag, "_done"}, sf_done, exp_done);
        tick();
        check({tag, "_done_end"}, sf_done, 1'b0);
    endtask

    initial begin
        logic        fl;
        logic [1:0]  rc;
        logic [31:0] rd;
        logic [8:0]  ra;
        logic        rv;

        rst_n = 1'b0;
        rd_en = 0; wr_en = 0; sf_valid = 0; sf_asid_valid = 0; ack = 0;
        raddr = 0; waddr = 0; rctx = 0; wctx = 0; sf_ctx = 0; wdata = 0; sf_asid = 0;
        rd_en64 = 0; wr_en64 = 0; ack64 = 0; raddr64 = 0; waddr64 = 0;
        rctx64 = 0; wctx64 = 0; wdata64 = 0;
        for (int c = 0; c < 3; c++) model[c] = '0;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        check_model("rst");
        check("rst_req", f_req, 1'b0);
        check("rst_all", f_all, 1'b0);
        check("rst_ctx", f_ctx, 2'd0);
        check("rst_asid", f_asid, 9'd0);
        check("rst_done", sf_done, 1'b0);
        check("rst_wr_rdy", wr_ready, 1'b1);
        check("rst_sf_rdy", sf_ready, 1'b1);
        wr_en = 1'b1; waddr = 12'h000; #1;
        check("rst_sf_rdy_wr", sf_ready, 1'b0);
        wr_en = 1'b0;

        // MODE-changing write to ctx1
        do_write(12'h180, 2'd1, 32'h8040_0123, fl);
        check("w1_flush_exp", f_req, fl);
        check("w1_mode", s_mode[1], 1'b1);
        check("w1_asid", s_asid[9 +: 9], 9'h001);
        check("w1_ppn", s_ppn[22 +: 22], 22'h000123);
        check("w1_all", f_all, 1'b1);
        check("w1_ctx", f_ctx, 2'd1);
        finish_flush("w1", 0, 1'b0);
        check_model("w1");

        // Same MODE: no flush; then MODE 0->1: flush
        do_write(12'h180, 2'd0, 32'h0000_0055, fl);
        check("w2_noflush", f_req, 1'b0);
        check_model("w2");
        do_write(12'h180, 2'd0, 32'h8000_0055, fl);
        check("w3_flush", f_req, 1'b1);
        check("w3_ctx", f_ctx, 2'd0);
        finish_flush("w3", 1, 1'b0);

        // ASID-specific sfence with ack stalled 5 cycles
        sf_valid = 1'b1; sf_ctx = 2'd0; sf_asid_valid = 1'b1; sf_asid = 9'h1A5;
        #1;
        check("sf1_rdy", sf_ready, 1'b1);
        tick();
        sf_valid = 1'b0;
        check("sf1_req", f_req, 1'b1);
        check("sf1_all", f_all, 1'b0);
        check("sf1_ctx", f_ctx, 2'd0);
        for (int k = 0; k < 5; k++) begin
            check("sf1_asid_hold", f_asid, 9'h1A5);
            check("sf1_sf_rdy_hold", sf_ready, 1'b0);
            check("sf1_done_hold", sf_done, 1'b0);
            if (k < 4) tick();
        end
        finish_flush("sf1", 0, 1'b1);

        // Write and sfence in the same cycle: write wins, sfence follows
        sf_valid = 1'b1; sf_ctx = 2'd1; sf_asid_valid = 1'b0; sf_asid = 9'h0AA;
        wr_en = 1'b1; waddr = 12'h180; wctx = 2'd2; wdata = 32'h8123_4567;
        #1;
        check("col_sf_rdy", sf_ready, 1'b0);
        check("col_wr_rdy", wr_ready, 1'b1);
        model[2] = 32'h8123_4567;
        tick();
        wr_en = 1'b0;
        check("col_req", f_req, 1'b1);
        check("col_ctx", f_ctx, 2'd2);
        check("col_all", f_all, 1'b1);
        check_model("col");
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("col_req_drop", f_req, 1'b0);
        check("col_no_done", sf_done, 1'b0);
        check("col_sf_rdy2", sf_ready, 1'b1);
        tick();
        sf_valid = 1'b0;
        check("col_sf_req", f_req, 1'b1);
        check("col_sf_ctx", f_ctx, 2'd1);
        check("col_sf_all", f_all, 1'b1);
        check("col_sf_asid", f_asid, 9'd0);
        finish_flush("col_sf", 0, 1'b1);

        // Out-of-range sfence context
        sf_valid = 1'b1; sf_ctx = 2'd3; sf_asid_valid = 1'b1; sf_asid = 9'h011;
        tick();
        sf_valid = 1'b0;
        check("oor_req", f_req, 1'b0);
        check("oor_done", sf_done, 1'b1);
        check("oor_wr_rdy", wr_ready, 1'b1);
        tick();
        check("oor_done_end", sf_done, 1'b0);
        rd_en = 1'b1; raddr = 12'h180; rctx = 2'd3; #1;
        check("oor_read", rdata, 32'd0);
        raddr = 12'h181; rctx = 2'd1; #1;
        check("bad_addr_read", rdata, 32'd0);
        rd_en = 1'b0;

        // Randomised writes and sfences against the model
        for (int it = 0; it < 40; it++) begin
            rc = 2'($urandom_range(0, 3));
            rd = $urandom;
            ack = 1'($urandom_range(0, 1));
            do_write(($urandom_range(0, 7) == 0) ? 12'h181 : 12'h180, rc, rd, fl);
            ack = 1'b0;
            check("rnd_w_req", f_req, fl);
            check("rnd_w_done", sf_done, 1'b0);
            if (fl) begin
                check("rnd_w_ctx", f_ctx, rc);
                check("rnd_w_all", f_all, 1'b1);
                finish_flush("rnd_w", $urandom_range(0, 3), 1'b0);
            end
            check_model("rnd");

            rc = 2'($urandom_range(0, 3));
            ra = 9'($urandom);
            rv = 1'($urandom_range(0, 1));
            sf_valid = 1'b1; sf_ctx = rc; sf_asid_valid = rv; sf_asid = ra;
            tick();
            sf_valid = 1'b0;
            if (rc < 3) begin
                check("rnd_sf_req", f_req, 1'b1);
                check("rnd_sf_ctx", f_ctx, rc);
                check("rnd_sf_all", f_all, !rv);
                check("rnd_sf_asid", f_asid, rv ? ra : 9'd0);
                finish_flush("rnd_sf", $urandom_range(0, 3), 1'b1);
            end else begin
                check("rnd_sf_oor_req", f_req, 1'b0);
                check("rnd_sf_oor_done", sf_done, 1'b1);
                tick();
            end
        end

        // Reset in the middle of an sfence flush
        do_write(12'h180, 2'd0, {~model[0][31], 31'h0000_0777}, fl);
        if (fl) finish_flush("pre_rst", 0, 1'b0);
        sf_valid = 1'b1; sf_ctx = 2'd0; sf_asid_valid = 1'b0;
        tick();
        sf_valid = 1'b0;
        check("mid_req", f_req, 1'b1);
        rst_n = 1'b0;
        ack = 1'b1;
        tick();
        rst_n = 1'b1;
        ack = 1'b0;
        for (int c = 0; c < 3; c++) model[c] = '0;
        check("mrst_req", f_req, 1'b0);
        check("mrst_done", sf_done, 1'b0);
        check_model("mrst");
        tick();
        check("mrst_done2", sf_done, 1'b0);
        check("mrst_req2", f_req, 1'b0);

        // Sv39 WARL: MODE=9 is dropped, MODE=8 is taken and flushes
        wr_en64 = 1'b1; waddr64 = 12'h180; wctx64 = 1'b0;
        wdata64 = {4'h9, 16'hBEEF, 44'h123_4567_89AB};
        tick();
        wr_en64 = 1'b0;
        check("x64_bad_mode", s_mode64[3:0], 4'h0);
        check("x64_bad_asid", s_asid64[15:0], 16'h0);
        check("x64_bad_req", f_req64, 1'b0);
        wr_en64 = 1'b1;
        wdata64 = {4'h8, 16'hBEEF, 44'h123_4567_89AB};
        tick();
        wr_en64 = 1'b0;
        check("x64_mode", s_mode64[3:0], 4'h8);
        check("x64_asid", s_asid64[15:0], 16'hBEEF);
        check("x64_ppn", s_ppn64[43:0], 44'h123_4567_89AB);
        check("x64_req", f_req64, 1'b1);
        check("x64_all", f_all64, 1'b1);
        ack64 = 1'b1;
        tick();
        ack64 = 1'b0;
        check("x64_req_drop", f_req64, 1'b0);
        check("x64_no_done", sf_done64, 1'b0);
        rd_en64 = 1'b1; raddr64 = 12'h180; rctx64 = 1'b0; #1;
        check("x64_read", rdata64, {4'h8, 16'hBEEF, 44'h123_4567_89AB});
        rctx64 = 1'b1; #1;
        check("x64_read_ctx1", rdata64, 64'd0);
        rd_en64 = 1'b0;

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
